j1_io_bus: RTL

- Parametrised I/O interconnect between the J1 CPU I/O port and N memory-mapped peripherals.
- Successor to the fixed 4-slot chip-select/read-mux.
- Adds:
  - a configurable slot count and base map;
  - a registered transaction FSM with per-slave ready (wait states);
  - timeout and unmapped-address error reporting;
  - a registered read-data return with a ready handshake to the master.

---
 rtl/j1_bus_pkg.sv | 18 +
 rtl/j1_bus_decoder.sv | 28 ++
 rtl/j1_io_bus.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/j1_bus_pkg.sv
// Shared definitions for the J1 I/O interconnect: FSM encoding, default widths,
// error read value and the position of the slot-decode field in the address.
package j1_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } bus_state_t;

    localparam int          DEF_DW         = 16;
    localparam int          DEF_SUB_AW     = 8;
    localparam logic [15:0] DEFAULT_RD_VAL = 16'h0666;
    localparam int          DEC_HI         = 15;
    localparam int          DEC_LO         = 8;
    localparam int          DEC_W          = DEC_HI - DEC_LO + 1;

endpackage

// File: rtl/j1_bus_decoder.sv
// Combinational slot decoder: compares the address high byte against every base
// and returns a one-hot select of the lowest matching slot plus a hit flag.
module j1_bus_decoder
    import j1_bus_pkg::*;
#(
    parameter int                  NSLOTS    = 4,
    parameter logic [NSLOTS*8-1:0] BASE_LIST = {8'h70, 8'h69, 8'h68, 8'h67}
)(
    input  logic [DEC_W-1:0]  addr_hi,
    output logic [NSLOTS-1:0] sel,
    output logic              hit
);

    logic [NSLOTS-1:0] match;

    // raw per-slot base comparison
    always_comb begin
        match = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            match[i] = (addr_hi == BASE_LIST[8*i +: 8]);
        end
    end

    // isolating the lowest set bit makes duplicate bases resolve to the lowest slot
    assign sel = match & (~match + NSLOTS'(1));
    assign hit = |match;

endmodule

// File: rtl/j1_io_bus.sv
// J1 I/O interconnect: registered IDLE/ACCESS/DONE transaction FSM with wait
// states, timeout and unmapped-address errors. Optional status page: J1_IO_BUS_STATUS_REG_EN.
module j1_io_bus
    import j1_bus_pkg::*;
#(
    parameter int                  NSLOTS      = 4,
    parameter int                  DW          = DEF_DW,
    parameter int                  SUB_AW      = DEF_SUB_AW,
    parameter logic [NSLOTS*8-1:0] BASE_LIST   = {8'h70, 8'h69, 8'h68, 8'h67},
    parameter int                  TIMEOUT     = 15,
    parameter logic [DW-1:0]       DEFAULT_RD  = DW'(DEFAULT_RD_VAL),
    parameter logic [7:0]          STATUS_BASE = 8'hFF
)(
    input  logic                 sys_clk_i,
    input  logic                 sys_rst_i,
    input  logic                 io_rd,
    input  logic                 io_wr,
    input  logic [15:0]          io_addr,
    input  logic [DW-1:0]        io_dout,
    output logic [DW-1:0]        io_din,
    output logic                 io_ready,
    output logic                 bus_err,
    output logic [NSLOTS-1:0]    cs,
    output logic [SUB_AW-1:0]    s_addr,
    output logic [DW-1:0]        s_wdata,
    output logic                 s_rd,
    output logic                 s_wr,
    input  logic [NSLOTS*DW-1:0] s_rdata,
    input  logic [NSLOTS-1:0]    s_ready
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    bus_state_t        state_r, state_nxt;
    logic [7:0]        cnt_r, cnt_nxt;
    logic              is_rd_r, is_rd_nxt;
    logic [NSLOTS-1:0] cs_nxt, dec_sel;
    logic              dec_hit, s_rd_nxt, s_wr_nxt, io_ready_nxt, bus_err_nxt;
    logic [SUB_AW-1:0] s_addr_nxt;
    logic [DW-1:0]     s_wdata_nxt, io_din_nxt, slv_rdata, status_rd;
    logic              slv_ready, status_hit;

    j1_bus_decoder #(
        .NSLOTS    (NSLOTS),
        .BASE_LIST (BASE_LIST)
    ) u_dec (
        .addr_hi (io_addr[DEC_HI:DEC_LO]),
        .sel     (dec_sel),
        .hit     (dec_hit)
    );

    // selected slave's read data and ready; other slots are masked out by cs
    always_comb begin
        slv_rdata = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            slv_rdata = slv_rdata | (s_rdata[i*DW +: DW] & {DW{cs[i]}});
        end
    end
    assign slv_ready = |(s_ready & cs);

`ifdef J1_IO_BUS_STATUS_REG_EN
    logic [15:0] addr_r, err_cnt_r, err_addr_r;
    logic        status_clr;

    assign status_hit = (io_addr[DEC_HI:DEC_LO] == STATUS_BASE);
    assign status_clr = (state_r == ST_IDLE) && io_wr && !io_rd && status_hit;

    // status page read mux
    always_comb begin
        case (io_addr[7:0])
            8'h00:   status_rd = DW'(err_cnt_r);
            8'h01:   status_rd = DW'(err_addr_r);
            default: status_rd = '0;
        endcase
    end

    // error counter and last-error address; a status write clear wins over a pulse
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            addr_r     <= 16'h0000;
            err_cnt_r  <= 16'h0000;
            err_addr_r <= 16'h0000;
        end else begin
            if (state_r == ST_IDLE && (io_rd || io_wr)) begin
                addr_r <= io_addr;
            end else begin
                addr_r <= addr_r;
            end
            if (status_clr) begin
                err_cnt_r  <= 16'h0000;
                err_addr_r <= 16'h0000;
            end else if (bus_err) begin
                err_cnt_r  <= (err_cnt_r == 16'hFFFF) ? err_cnt_r : err_cnt_r + 16'd1;
                err_addr_r <= addr_r;
            end else begin
                err_cnt_r  <= err_cnt_r;
                err_addr_r <= err_addr_r;
            end
        end
    end
`else
    assign status_hit = 1'b0;
    assign status_rd  = '0;
`endif

    // next-state and next-output logic
    always_comb begin
        state_nxt    = state_r;
        cnt_nxt      = cnt_r;
        is_rd_nxt    = is_rd_r;
        cs_nxt       = cs;
        s_rd_nxt     = 1'b0;
        s_wr_nxt     = 1'b0;
        s_addr_nxt   = s_addr;
        s_wdata_nxt  = s_wdata;
        io_din_nxt   = io_din;
        io_ready_nxt = 1'b0;
        bus_err_nxt  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (io_rd || io_wr) begin
                    s_addr_nxt  = io_addr[SUB_AW-1:0];
                    s_wdata_nxt = io_dout;
                    is_rd_nxt   = io_rd;
                    cnt_nxt     = 8'd0;
                    if ((io_rd && io_wr) || !(dec_hit || status_hit)) begin
                        state_nxt    = ST_DONE;
                        io_din_nxt   = DEFAULT_RD;
                        io_ready_nxt = 1'b1;
                        bus_err_nxt  = 1'b1;
                    end else if (status_hit) begin
                        state_nxt    = ST_DONE;
                        io_ready_nxt = 1'b1;
                        io_din_nxt   = io_rd ? status_rd : io_din;
                    end else begin
                        state_nxt = ST_ACCESS;
                        cs_nxt    = dec_sel;
                        s_rd_nxt  = io_rd;
                        s_wr_nxt  = io_wr;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                cnt_nxt = cnt_r + 8'd1;
                if (slv_ready) begin
                    state_nxt    = ST_DONE;
                    cs_nxt       = '0;
                    io_ready_nxt = 1'b1;
                    io_din_nxt   = is_rd_r ? slv_rdata : io_din;
                end else if (cnt_nxt == TIMEOUT_CNT) begin
                    state_nxt    = ST_DONE;
                    cs_nxt       = '0;
                    io_ready_nxt = 1'b1;
                    bus_err_nxt  = 1'b1;
                    io_din_nxt   = is_rd_r ? DEFAULT_RD : io_din;
                end else begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                cs_nxt    = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                cs_nxt    = '0;
            end
        endcase
    end

    // state and registered outputs; reset drops cs and strobes at once
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 8'd0;
            is_rd_r  <= 1'b0;
            cs       <= '0;
            s_rd     <= 1'b0;
            s_wr     <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
            io_din   <= '0;
            io_ready <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            state_r  <= state_nxt;
            cnt_r    <= cnt_nxt;
            is_rd_r  <= is_rd_nxt;
            cs       <= cs_nxt;
            s_rd     <= s_rd_nxt;
            s_wr     <= s_wr_nxt;
            s_addr   <= s_addr_nxt;
            s_wdata  <= s_wdata_nxt;
            io_din   <= io_din_nxt;
            io_ready <= io_ready_nxt;
            bus_err  <= bus_err_nxt;
        end
    end

endmodule
